// File: rtl/axil_panel_ctrl_if.sv
// AXI4-Lite bus bundle for the front-panel controller.
// Holds the five AXI4-Lite channels (AW, W, B, AR, R) with an 8-bit address
// and 32-bit data. Write strobes are not carried; all writes are full-word.
// master : drives addresses, write data, valids and the response readies.
// slave  : drives the address/data readies, the responses and read data.
interface axil_panel_ctrl_if;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_panel_ctrl.sv
// Front-panel register controller behind an AXI4-Lite slave port.
// Drives 16 LEDs, synchronizes 16 switches for readback and scans a
// 4-digit multiplexed seven-segment display.
//
// Ports:
//   control_aclk    : single clock for everything
//   control_aresetn : asynchronous active-low reset
//   control         : AXI4-Lite slave (axil_panel_ctrl_if.slave)
//   sw              : raw asynchronous switch inputs
//   led             : LED drive, active-high
//   seg             : segment cathodes, active-low, bit 7 = dp
//   an              : digit anodes, active-low
//
// Register map (addr[7:2] decoded, addr[1:0] ignored):
//   0x00 LED      RW [15:0]
//   0x04 SW       RO [15:0] synchronized switches
//   0x08 SEG_DATA RW byte n = raw active-low pattern for digit n
//   0x0C SEG_CTRL RW bit 0 scan enable, bits [7:4] digit mask
//   0x10 SCRATCH  RW
//   0x14 ID       RO ID_VALUE
//
// Write FSM:
//   state  | meaning
//   W_IDLE | waiting for awvalid and wvalid together
//   W_ACK  | awready/wready high; register written on this edge
//   W_RESP | bvalid high until bready
// Read FSM:
//   state  | meaning
//   R_IDLE | waiting for arvalid
//   R_ACK  | arready high; rdata/rresp captured on this edge
//   R_DATA | rvalid high until rready
module axil_panel_ctrl #(
    parameter int          SCAN_DIV = 100000,
    parameter logic [31:0] ID_VALUE = 32'h5041_4E01
) (
    input  logic               control_aclk,
    input  logic               control_aresetn,
    axil_panel_ctrl_if.slave   control,
    input  logic [15:0]        sw,
    output logic [15:0]        led,
    output logic [7:0]         seg,
    output logic [3:0]         an
);

    localparam int                 DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [5:0] A_LED  = 6'h00;
    localparam logic [5:0] A_SW   = 6'h01;
    localparam logic [5:0] A_SEGD = 6'h02;
    localparam logic [5:0] A_SEGC = 6'h03;
    localparam logic [5:0] A_SCR  = 6'h04;
    localparam logic [5:0] A_ID   = 6'h05;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    r_w_state, w_w_state_nxt;
    r_state_t    r_r_state, w_r_state_nxt;

    logic        r_awready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [15:0] r_led;
    logic [31:0] r_seg_data;
    logic        r_scan_en;
    logic [3:0]  r_dig_mask;
    logic [31:0] r_scratch;

    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [7:0]       r_seg;
    logic [3:0]       r_an;

    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [5:0]  w_wr_idx;
    logic        w_wr_ok;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_digit_on;
    logic [7:0]  w_digit_pat;
    logic        w_unused;

    // Address LSBs are intentionally not decoded.
    assign w_unused = ^{control.awaddr[1:0], control.araddr[1:0]};

    // ---------------- write channel ----------------
    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_awready <= (w_w_state_nxt == W_ACK);
            r_bvalid  <= (w_w_state_nxt == W_RESP);
        end
    end

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE: if (control.awvalid && control.wvalid) w_w_state_nxt = W_ACK;
            W_ACK:  w_w_state_nxt = W_RESP;
            W_RESP: if (control.bready) w_w_state_nxt = W_IDLE;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    assign w_wr_fire = (r_w_state == W_ACK);
    assign w_wr_idx  = control.awaddr[7:2];
    assign w_wr_ok   = (w_wr_idx == A_LED)  || (w_wr_idx == A_SEGD) ||
                       (w_wr_idx == A_SEGC) || (w_wr_idx == A_SCR);

    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_led      <= '0;
            r_seg_data <= '0;
            r_scan_en  <= 1'b0;
            r_dig_mask <= '0;
            r_scratch  <= '0;
            r_bresp    <= RESP_OKAY;
        end else if (w_wr_fire) begin
            r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            case (w_wr_idx)
                A_LED:  r_led      <= control.wdata[15:0];
                A_SEGD: r_seg_data <= control.wdata;
                A_SEGC: begin
                    r_scan_en  <= control.wdata[0];
                    r_dig_mask <= control.wdata[7:4];
                end
                A_SCR:  r_scratch  <= control.wdata;
                default: ;
            endcase
        end
    end

    assign control.awready = r_awready;
    assign control.wready  = r_awready;
    assign control.bvalid  = r_bvalid;
    assign control.bresp   = r_bresp;

    // ---------------- read channel ----------------
    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arready <= (w_r_state_nxt == R_ACK);
            r_rvalid  <= (w_r_state_nxt == R_DATA);
        end
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE: if (control.arvalid) w_r_state_nxt = R_ACK;
            R_ACK:  w_r_state_nxt = R_DATA;
            R_DATA: if (control.rready) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    assign w_rd_fire = (r_r_state == R_ACK);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (control.araddr[7:2])
            A_LED:  w_rd_data = {16'h0000, r_led};
            A_SW:   w_rd_data = {16'h0000, r_sw_sync};
            A_SEGD: w_rd_data = r_seg_data;
            A_SEGC: w_rd_data = {24'h000000, r_dig_mask, 3'b000, r_scan_en};
            A_SCR:  w_rd_data = r_scratch;
            A_ID:   w_rd_data = ID_VALUE;
            default: w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Reads see register values before any write landing on the same edge.
    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_fire) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    assign control.arready = r_arready;
    assign control.rvalid  = r_rvalid;
    assign control.rdata   = r_rdata;
    assign control.rresp   = r_rresp;

    // ---------------- switch synchronizer ----------------
    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign led = r_led;

    // ---------------- display scan ----------------
    // Counters park at zero while disabled so enabling always starts at digit 0.
    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (!r_scan_en) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Masked digits still use their slot; they are simply blanked.
    assign w_digit_on  = r_scan_en && r_dig_mask[r_idx];
    assign w_digit_pat = r_seg_data[{r_idx, 3'b000} +: 8];

    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end else if (w_digit_on) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_digit_pat;
        end else begin
            r_an  <= 4'hF;
            r_seg <= 8'hFF;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: doc/axil_panel_ctrl.md
# axil_panel_ctrl

AXI4-Lite register controller for the board front panel, sitting between the `control_*` AXI4-Lite port and the LED, switch and seven-segment pins. It decodes single-beat reads and writes into a small register map and drives the 16 LEDs. It synchronizes the 16 switches for readback. It runs the time-multiplexed scan scheduler for the 4-digit seven-segment display. All logic is in the control clock domain.

## Interface
- `SCAN_DIV`, default 100000: control-clock cycles per digit slot (1 ms at 100 MHz). Legal range is ≥ 2.
- `ID_VALUE`, default 32'h5041_4E01: constant returned by the ID register.

Ports:
- `control_aclk` in 1: the single clock.
- `control_aresetn` in 1: reset, asynchronous, active-low.
- `control_awaddr` in 8 / `control_awvalid` in 1 / `control_awready` out 1: write address channel.
- `control_wdata` in 32 / `control_wvalid` in 1 / `control_wready` out 1: write data channel (no strobes; full-word writes only).
- `control_bresp` out 2 / `control_bvalid` out 1 / `control_bready` in 1: write response channel.
- `control_araddr` in 8 / `control_arvalid` in 1 / `control_arready` out 1: read address channel.
- `control_rdata` out 32 / `control_rresp` out 2 / `control_rvalid` out 1 / `control_rready` in 1: read data channel.
- `sw` in 16: raw switch inputs, asynchronous.
- `led` out 16: LED drive, active-high.
- `seg` out 8: segment cathodes, active-low, bit 7 = dp.
- `an` out 4: digit anodes, active-low.

## Operation
- Address decode uses `addr[7:2]`; `addr[1:0]` is ignored.
  - 0x00 LED (RW): bits [15:0].
  - 0x04 SW (RO): bits [15:0] from the 2-flop synchronizer.
  - 0x08 SEG_DATA (RW): byte n is the raw active-low pattern for digit n.
  - 0x0C SEG_CTRL (RW): bit 0 = scan enable, bits [7:4] = digit enable mask. Other bits read 0.
  - 0x10 SCRATCH (RW): 32 bits.
  - 0x14 ID (RO): `ID_VALUE`.
- Unmapped read: `rdata` = 0, `rresp` = 2'b10 (SLVERR).
- Unmapped write, or write to a RO register: no state change, `bresp` = 2'b10.
- Mapped accesses return 2'b00.
- Write channel FSM: W_IDLE -> W_ACK -> W_RESP -> W_IDLE.
  - W_IDLE -> W_ACK when `awvalid` and `wvalid` are both sampled high. A lone `awvalid` or lone `wvalid` waits without acceptance.
  - W_ACK: `awready` = `wready` = 1 for exactly one cycle. The register updates on that edge.
  - W_RESP: `bvalid` = 1 with `bresp` held stable until `bready` is sampled high, then return to W_IDLE.
- Read channel FSM: R_IDLE -> R_ACK -> R_DATA -> R_IDLE.
  - R_ACK: `arready` = 1 for one cycle. `rdata` and `rresp` are captured on that edge.
  - R_DATA: `rvalid` is held with data stable until `rready` is sampled high.
- The read and write FSMs are independent. If a read and a write to the same register are captured on the same edge, the read returns the pre-write value.
- Scan scheduler:
  - Divider `div` counts 0..`SCAN_DIV`-1. At the terminal count it wraps to 0 and digit index `idx` (2 bits) increments, wrapping 3 -> 0.
  - Digit active when enable = 1 and mask[idx] = 1.
  - Active digit: `an` = ~(1 << idx), `seg` = SEG_DATA byte[idx].
  - Inactive digit: `an` = 4'hF, `seg` = 8'hFF. The slot is still consumed (no skipping).
  - With enable = 0, `div` and `idx` are held at 0.
  - An enable 0 -> 1 transition starts scanning at idx 0, div 0.
  - Writes to SEG_DATA or the mask take effect on the next `seg`/`an` register update, without restarting the scan.

## Timing
- All outputs are registered.
- Reset values, applied asynchronously on `control_aresetn` low:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp` = 0; `rdata` = 0.
  - `led` = 0, `seg` = 8'hFF, `an` = 4'hF.
  - All registers = 0; synchronizer = 0; `div` = 0, `idx` = 0.
- Write latency: valids high at cycle 0 -> ready pulse at cycle 1 -> `bvalid` at cycle 2. `led` reflects the LED write at cycle 2.
- Read latency: `arvalid` at cycle 0 -> `arready` at cycle 1 -> `rvalid` at cycle 2.
- Throughput: at most one transaction per channel per 3 cycles when `bready`/`rready` are held high.
- Switch readback: a `sw` change is visible in SW reads 2-3 cycles later.
- Scan: each digit is driven for exactly `SCAN_DIV` cycles. `an`/`seg` change one cycle after the `div` wrap.
- Reset mid-transaction: the channel drops to IDLE with valid and ready low; the transaction is lost and the master must reissue it.

## Test plan
- Reset: hold `control_aresetn` low mid-scan and mid-write -> `an` = F, `seg` = FF, `led` = 0, all valid/ready = 0 within the same cycle.
- Write LED then read back: write 0x00 = 0x0000A5C3 -> `bresp` 00, `bvalid` at cycle 2, `led` = 0xA5C3; read 0x00 -> `rdata` 0x0000A5C3.
- Staggered write and backpressure: `awvalid` 3 cycles before `wvalid`, `bready` low for 5 cycles -> no ready until both are valid, `bvalid` held with stable `bresp` until `bready`.
- Errors: write 0x14, read 0x3C -> `bresp` 10 with ID unchanged (reads 0x50414E01); `rresp` 10 with `rdata` 0.
- Scan with `SCAN_DIV` = 4: SEG_DATA = 0x11223344, SEG_CTRL = 0xB1 -> per 4-cycle slot, (`an`, `seg`) = (E, 44), (D, 33), (F, FF), (7, 11), repeating.
- Simultaneous read and write of SCRATCH (old 0x1, new 0x2) on the same edge -> read returns 0x1; a following read returns 0x2.
